// File: rtl/program_loader_pkg.sv
// Shared types for the boot-time program loader: FSM state encoding and frame constants.
package program_loader_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA_LO,
        ST_DATA_HI,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

endpackage

// File: rtl/program_loader_watchdog.sv
// Inter-byte watchdog for program_loader: cleared by load, counts while enabled,
// flags expire on the LIMIT-th consecutive idle cycle.
module loader_watchdog #(
    parameter int LIMIT = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count_en,
    output logic expire
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    assign expire = count_en && !load && (cnt == W'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load || !count_en)
            cnt <= '0;
        else if (!expire)
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: unpacks a framed byte stream into 16-bit program-memory writes and
// releases the CPU once the XOR checksum matches. Optional inter-byte timeout: LOADER_TIMEOUT_EN.
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int          MAX_HALFWORDS  = 1024,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,
    input  logic        restart_i,
    output logic        program_mem_write_en_o,
    output logic [15:0] instruction_o,
    output logic [31:0] instruction_addr_o,
    output logic        cpu_hold_o,
    output logic        done_o,
    output logic        error_o
);
    localparam int CW = $clog2(MAX_HALFWORDS + 1);

    loader_state_t state, state_nxt;
    logic [7:0]    len_lo;
    logic [7:0]    csum;
    logic [15:0]   len;
    logic [CW-1:0] count;
    logic          xfer;
    logic          timeout;

    assign len  = {rx_data_i, len_lo};
    assign xfer = rx_valid_i && rx_ready_o;

`ifdef LOADER_TIMEOUT_EN
    logic wd_en;
    assign wd_en = !(state inside {ST_IDLE, ST_DONE, ST_ERROR});

    loader_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk      (clk_i),
        .rst_n    (reset_i),
        .load     (xfer),
        .count_en (wd_en),
        .expire   (timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (xfer && rx_data_i == SYNC_BYTE) state_nxt = ST_LEN_LO;
            ST_LEN_LO:  if (xfer) state_nxt = ST_LEN_HI;
            ST_LEN_HI:
                if (xfer) begin
                    if (len == 16'h0)
                        state_nxt = ST_CHECK;
                    else if (32'(len) > 32'(MAX_HALFWORDS))
                        state_nxt = ST_ERROR;
                    else
                        state_nxt = ST_DATA_LO;
                end
            ST_DATA_LO: if (xfer) state_nxt = ST_DATA_HI;
            ST_DATA_HI: if (xfer) state_nxt = ST_WRITE;
            ST_WRITE:   state_nxt = (count == CW'(1)) ? ST_CHECK : ST_DATA_LO;
            ST_CHECK:   if (xfer) state_nxt = (rx_data_i == csum) ? ST_DONE : ST_ERROR;
            ST_DONE,
            ST_ERROR:   if (restart_i) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        if (timeout)
            state_nxt = ST_ERROR;
    end

    // Ready is gated by reset so the stream sees no acceptance while reset is held.
    always_comb begin
        rx_ready_o             = reset_i && (state inside {ST_IDLE, ST_LEN_LO, ST_LEN_HI,
                                                           ST_DATA_LO, ST_DATA_HI, ST_CHECK});
        program_mem_write_en_o = (state == ST_WRITE);
        cpu_hold_o             = (state != ST_DONE);
        done_o                 = (state == ST_DONE);
        error_o                = (state == ST_ERROR);
    end

    // Address/counter step in the cycle after the write pulse so the write sees stable values.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            len_lo             <= '0;
            csum               <= '0;
            count              <= '0;
            instruction_o      <= '0;
            instruction_addr_o <= BASE_ADDR;
        end else begin
            case (state)
                ST_LEN_LO: if (xfer) len_lo <= rx_data_i;
                ST_LEN_HI:
                    if (xfer) begin
                        csum  <= '0;
                        count <= len[CW-1:0];
                    end
                ST_DATA_LO:
                    if (xfer) begin
                        instruction_o[7:0] <= rx_data_i;
                        csum               <= csum ^ rx_data_i;
                    end
                ST_DATA_HI:
                    if (xfer) begin
                        instruction_o[15:8] <= rx_data_i;
                        csum                <= csum ^ rx_data_i;
                    end
                ST_WRITE: begin
                    instruction_addr_o <= instruction_addr_o + 32'd2;
                    count              <= count - CW'(1);
                end
                ST_DONE,
                ST_ERROR: if (restart_i) instruction_addr_o <= BASE_ADDR;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; base address sits just below 2^32 so wraparound is exercised.
module tb_program_loader;
    localparam logic [31:0] BASE = 32'hFFFF_FFFC;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_ready_o;
    logic        restart_i = 1'b0;
    logic        program_mem_write_en_o;
    logic [15:0] instruction_o;
    logic [31:0] instruction_addr_o;
    logic        cpu_hold_o, done_o, error_o;

    int vectors = 0;
    int miscompares = 0;
    int bad_ready = 0;
    int dup_we = 0;
    logic we_prev = 1'b0;
    logic [31:0] wr_addr[$];
    logic [15:0] wr_data[$];
    byte_q_t frame;

    program_loader #(.BASE_ADDR(BASE)) dut (
        .clk_i                  (clk),
        .reset_i                (reset_i),
        .rx_valid_i             (rx_valid_i),
        .rx_data_i              (rx_data_i),
        .rx_ready_o             (rx_ready_o),
        .restart_i              (restart_i),
        .program_mem_write_en_o (program_mem_write_en_o),
        .instruction_o          (instruction_o),
        .instruction_addr_o     (instruction_addr_o),
        .cpu_hold_o             (cpu_hold_o),
        .done_o                 (done_o),
        .error_o                (error_o)
    );

    always #5 clk = ~clk;

    // Write monitor sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (program_mem_write_en_o) begin
            wr_addr.push_back(instruction_addr_o);
            wr_data.push_back(instruction_o);
            if (rx_ready_o) bad_ready++;
            if (we_prev) dup_we++;
        end
        we_prev = program_mem_write_en_o;
    end

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        while (!rx_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready_o) begin
            vectors++; miscompares++;
            $display("FAIL ready_timeout: rx_ready_o=%0b required 1 for byte %h", rx_ready_o, b);
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input byte_q_t f);
        foreach (f[i]) send_byte(f[i]);
        rx_valid_i = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        bad_ready = 0;
        dup_we = 0;
    endtask

    task automatic pulse_restart();
        restart_i = 1'b1;
        @(negedge clk);
        restart_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++; if (rx_ready_o !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b want 0", rx_ready_o); end
        vectors++; if (program_mem_write_en_o !== 1'b0) begin miscompares++; $display("FAIL rst_we: got %b want 0", program_mem_write_en_o); end
        vectors++; if (instruction_o !== 16'h0) begin miscompares++; $display("FAIL rst_instr: got %h want 0000", instruction_o); end
        vectors++; if (instruction_addr_o !== BASE) begin miscompares++; $display("FAIL rst_addr: got %h want %h", instruction_addr_o, BASE); end
        vectors++; if (cpu_hold_o !== 1'b1) begin miscompares++; $display("FAIL rst_hold: got %b want 1", cpu_hold_o); end
        vectors++; if ({done_o, error_o} !== 2'b00) begin miscompares++; $display("FAIL rst_flags: got %b want 00", {done_o, error_o}); end
        reset_i = 1'b1;
        @(negedge clk);
        vectors++; if (rx_ready_o !== 1'b1) begin miscompares++; $display("FAIL idle_ready: got %b want 1", rx_ready_o); end
    endtask

    task automatic test_good_frame();
        clear_log();
        // XOR of 34 12 78 56 is 08
        frame = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h08};
        send_frame(frame);
        vectors++; if (wr_addr.size() !== 2) begin miscompares++; $display("FAIL good_nwrites: got %0d want 2", wr_addr.size()); end
        if (wr_addr.size() == 2) begin
            vectors++; if (wr_addr[0] !== BASE || wr_data[0] !== 16'h1234) begin miscompares++; $display("FAIL good_w0: got %h@%h want 1234@%h", wr_data[0], wr_addr[0], BASE); end
            vectors++; if (wr_addr[1] !== 32'hFFFF_FFFE || wr_data[1] !== 16'h5678) begin miscompares++; $display("FAIL good_w1: got %h@%h want 5678@fffffffe", wr_data[1], wr_addr[1]); end
        end
        vectors++; if ({done_o, error_o, cpu_hold_o} !== 3'b100) begin miscompares++; $display("FAIL good_flags: done/err/hold got %b want 100", {done_o, error_o, cpu_hold_o}); end
        vectors++; if (rx_ready_o !== 1'b0) begin miscompares++; $display("FAIL done_ready: got %b want 0", rx_ready_o); end
        pulse_restart();
        vectors++; if ({done_o, cpu_hold_o, rx_ready_o} !== 3'b011) begin miscompares++; $display("FAIL good_restart: done/hold/ready got %b want 011", {done_o, cpu_hold_o, rx_ready_o}); end
        vectors++; if (instruction_addr_o !== BASE) begin miscompares++; $display("FAIL good_restart_addr: got %h want %h", instruction_addr_o, BASE); end
    endtask

    task automatic test_bad_csum();
        clear_log();
        frame = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h00};
        send_frame(frame);
        vectors++; if (wr_addr.size() !== 2) begin miscompares++; $display("FAIL bad_nwrites: got %0d want 2", wr_addr.size()); end
        vectors++; if ({done_o, error_o, cpu_hold_o} !== 3'b011) begin miscompares++; $display("FAIL bad_flags: done/err/hold got %b want 011", {done_o, error_o, cpu_hold_o}); end
        vectors++; if (instruction_addr_o !== 32'h0) begin miscompares++; $display("FAIL bad_addr_wrap: got %h want 00000000", instruction_addr_o); end
        pulse_restart();
        vectors++; if ({error_o, cpu_hold_o, rx_ready_o} !== 3'b011) begin miscompares++; $display("FAIL bad_restart: err/hold/ready got %b want 011", {error_o, cpu_hold_o, rx_ready_o}); end
        vectors++; if (instruction_addr_o !== BASE) begin miscompares++; $display("FAIL bad_restart_addr: got %h want %h", instruction_addr_o, BASE); end
    endtask

    task automatic test_junk_empty();
        clear_log();
        frame = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(frame);
        vectors++; if (wr_addr.size() !== 0) begin miscompares++; $display("FAIL empty_nwrites: got %0d want 0", wr_addr.size()); end
        vectors++; if ({done_o, error_o, cpu_hold_o} !== 3'b100) begin miscompares++; $display("FAIL empty_flags: done/err/hold got %b want 100", {done_o, error_o, cpu_hold_o}); end
        pulse_restart();
    endtask

    task automatic test_too_long();
        clear_log();
        frame = '{8'hA5, 8'h01, 8'h04};
        send_frame(frame);
        vectors++; if ({done_o, error_o, cpu_hold_o} !== 3'b011) begin miscompares++; $display("FAIL long_flags: done/err/hold got %b want 011", {done_o, error_o, cpu_hold_o}); end
        repeat (3) @(negedge clk);
        vectors++; if (wr_addr.size() !== 0) begin miscompares++; $display("FAIL long_nwrites: got %0d want 0", wr_addr.size()); end
        pulse_restart();
        clear_log();
        // exactly MAX_HALFWORDS must be accepted: check it reaches the payload phase, then reset out
        frame = '{8'hA5, 8'h00, 8'h04, 8'h01, 8'h02};
        send_frame(frame);
        repeat (2) @(negedge clk);
        vectors++; if (wr_addr.size() !== 1 || error_o !== 1'b0) begin miscompares++; $display("FAIL max_len: writes %0d err %b want 1 write err 0", wr_addr.size(), error_o); end
        reset_i = 1'b0;
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        clear_log();
        // XOR of 11..66 is 77; valid stays high through the write cycles
        frame = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        send_frame(frame);
        vectors++; if (wr_addr.size() !== 3) begin miscompares++; $display("FAIL b2b_nwrites: got %0d want 3", wr_addr.size()); end
        if (wr_addr.size() == 3) begin
            vectors++; if (wr_data[0] !== 16'h2211 || wr_data[1] !== 16'h4433 || wr_data[2] !== 16'h6655) begin miscompares++; $display("FAIL b2b_data: got %h %h %h want 2211 4433 6655", wr_data[0], wr_data[1], wr_data[2]); end
            vectors++; if (wr_addr[0] !== BASE || wr_addr[1] !== 32'hFFFF_FFFE || wr_addr[2] !== 32'h0) begin miscompares++; $display("FAIL b2b_addr: got %h %h %h want fffffffc fffffffe 00000000", wr_addr[0], wr_addr[1], wr_addr[2]); end
        end
        vectors++; if (bad_ready !== 0 || dup_we !== 0) begin miscompares++; $display("FAIL b2b_handshake: ready-in-write %0d long-pulse %0d want 0 0", bad_ready, dup_we); end
        vectors++; if (done_o !== 1'b1) begin miscompares++; $display("FAIL b2b_done: got %b want 1", done_o); end
        pulse_restart();
    endtask

    task automatic test_restart_ignored();
        clear_log();
        frame = '{8'hA5, 8'h01};
        send_frame(frame);
        pulse_restart();
        frame = '{8'h00, 8'hAA, 8'hBB, 8'h11};
        send_frame(frame);
        vectors++; if (wr_data.size() !== 1 || done_o !== 1'b1) begin miscompares++; $display("FAIL restart_ignored: writes %0d done %b want 1 1", wr_data.size(), done_o); end
        if (wr_data.size() == 1) begin
            vectors++; if (wr_data[0] !== 16'hBBAA) begin miscompares++; $display("FAIL restart_ignored_data: got %h want bbaa", wr_data[0]); end
        end
        pulse_restart();
    endtask

    task automatic test_reset_midload();
        clear_log();
        frame = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78};
        send_frame(frame);
        reset_i = 1'b0;
        #1;
        vectors++; if ({rx_ready_o, program_mem_write_en_o, cpu_hold_o, done_o, error_o} !== 5'b00100) begin miscompares++; $display("FAIL midrst_ctl: got %b want 00100", {rx_ready_o, program_mem_write_en_o, cpu_hold_o, done_o, error_o}); end
        vectors++; if (instruction_o !== 16'h0 || instruction_addr_o !== BASE) begin miscompares++; $display("FAIL midrst_data: got %h@%h want 0000@%h", instruction_o, instruction_addr_o, BASE); end
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        clear_log();
        frame = '{8'hA5, 8'h02, 8'h00, 8'hCD, 8'hAB, 8'h01, 8'h00, 8'h67};
        send_frame(frame);
        vectors++; if (wr_addr.size() !== 2 || done_o !== 1'b1) begin miscompares++; $display("FAIL midrst_reload: writes %0d done %b want 2 1", wr_addr.size(), done_o); end
        if (wr_addr.size() == 2) begin
            vectors++; if (wr_addr[0] !== BASE || wr_data[0] !== 16'hABCD || wr_data[1] !== 16'h0001) begin miscompares++; $display("FAIL midrst_w: got %h@%h,%h want abcd@%h,0001", wr_data[0], wr_addr[0], wr_data[1], BASE); end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_junk_empty();
        test_too_long();
        test_back_to_back();
        test_restart_ignored();
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
